// File: rtl/tt_sweep_checker.sv
// Sweeps all 16 minterms through a 4-input netlist, captures y0 into a truth table
// and compares it with EXPECTED_TT. Define MISMATCH_CNT_EN to add the mism_cnt port.
module tt_sweep_checker #(
    parameter logic [15:0] EXPECTED_TT = 16'h177E,
    parameter int          DUT_LAT     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  x_out,
    input  logic        y_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        pass,
`ifdef MISMATCH_CNT_EN
    output logic [4:0]  mism_cnt,
`endif
    output logic [3:0]  fail_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] LAT2 = DUT_LAT[1:0];

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  cap_idx_r;
    logic [1:0]  lag_r;
    logic        active_s;
    logic        cap_en_s;
    logic        last_cap_s;
    logic        accept_s;
    logic [15:0] tt_next_s;
    logic [15:0] diff_s;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                r = i[3:0];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Capture lags the driven minterm by DUT_LAT cycles; lag_r counts that delay down.
    assign active_s   = (state_r == SWEEP) || (state_r == DRAIN);
    assign cap_en_s   = active_s && (lag_r == 2'd0);
    assign last_cap_s = cap_en_s && (cap_idx_r == 4'd15);
    assign accept_s   = (state_r == IDLE) && start;
    assign diff_s     = tt_next_s ^ EXPECTED_TT;

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SWEEP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SWEEP: begin
                if (last_cap_s) begin
                    state_next_s = DONE;
                end else if (x_out == 4'd15) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = SWEEP;
                end
            end
            DRAIN: begin
                if (last_cap_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Truth table with the current capture folded in
    always_comb begin
        tt_next_s = tt;
        if (cap_en_s) begin
            tt_next_s[cap_idx_r] = y_in;
        end else begin
            tt_next_s = tt;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            x_out     <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tt        <= 16'd0;
            pass      <= 1'b0;
            fail_idx  <= 4'd0;
            cap_idx_r <= 4'd0;
            lag_r     <= 2'd0;
`ifdef MISMATCH_CNT_EN
            mism_cnt  <= 5'd0;
`endif
        end else begin
            busy <= (state_next_s == SWEEP) || (state_next_s == DRAIN);
            done <= (state_next_s == DONE);
            if (accept_s) begin
                x_out     <= 4'd0;
                tt        <= 16'd0;
                pass      <= 1'b0;
                fail_idx  <= 4'd0;
                cap_idx_r <= 4'd0;
                lag_r     <= LAT2;
`ifdef MISMATCH_CNT_EN
                mism_cnt  <= 5'd0;
`endif
            end else begin
                tt <= tt_next_s;
                if ((state_r == SWEEP) && (state_next_s == SWEEP)) begin
                    x_out <= x_out + 4'd1;
                end else begin
                    x_out <= 4'd0;
                end
                if (cap_en_s) begin
                    cap_idx_r <= cap_idx_r + 4'd1;
                end
                if (active_s && (lag_r != 2'd0)) begin
                    lag_r <= lag_r - 2'd1;
                end
                // Results come from the final table, including the capture on this edge
                if (active_s && (state_next_s == DONE)) begin
                    pass     <= (tt_next_s == EXPECTED_TT);
                    fail_idx <= lowest_set(diff_s);
`ifdef MISMATCH_CNT_EN
                    mism_cnt <= popcount16(diff_s);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: one instance with DUT_LAT=0, one with DUT_LAT=2.
// mism_cnt is checked only when MISMATCH_CNT_EN is defined.
module tb_tt_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start0, start2;
    logic [3:0]  x0, x2, fail0, fail2;
    logic        y0, y2, busy0, busy2, done0, done2, pass0, pass2;
    logic [15:0] tt0, tt2;
    logic [15:0] f0 = 16'h177E;
    logic [15:0] f2 = 16'h177E;
    logic        d1, d2;

    int checks   = 0;
    int failures = 0;

    logic        sel;
    logic        s_busy, s_done, s_pass;
    logic [3:0]  s_x, s_fail;
    logic [15:0] s_tt;
    logic [3:0]  xs [0:19];

    assign y0 = f0[x0];
    always @(posedge clk) begin
        d1 <= f2[x2];
        d2 <= d1;
    end
    assign y2 = d2;

`ifdef MISMATCH_CNT_EN
    logic [4:0] mism0, mism2, s_mism;
    assign s_mism = sel ? mism2 : mism0;
`endif

    assign s_busy = sel ? busy2 : busy0;
    assign s_done = sel ? done2 : done0;
    assign s_pass = sel ? pass2 : pass0;
    assign s_x    = sel ? x2 : x0;
    assign s_fail = sel ? fail2 : fail0;
    assign s_tt   = sel ? tt2 : tt0;

    tt_sweep_checker #(.EXPECTED_TT(16'h177E), .DUT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .x_out(x0), .y_in(y0),
        .busy(busy0), .done(done0), .tt(tt0), .pass(pass0),
`ifdef MISMATCH_CNT_EN
        .mism_cnt(mism0),
`endif
        .fail_idx(fail0)
    );

    tt_sweep_checker #(.EXPECTED_TT(16'h177E), .DUT_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .x_out(x2), .y_in(y2),
        .busy(busy2), .done(done2), .tt(tt2), .pass(pass2),
`ifdef MISMATCH_CNT_EN
        .mism_cnt(mism2),
`endif
        .fail_idx(fail2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a sweep on the selected instance and returns in its done cycle (lat=0 on timeout).
    task automatic run_sweep(input logic s, input logic [15:0] f, input bit poke, output int lat);
        bit got;
        sel = s;
        if (s) f2 = f; else f0 = f;
        if (s) start2 = 1'b1; else start0 = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 60 && !got; c++) begin
            tick();
            start0 = 1'b0;
            start2 = 1'b0;
            if (c == 1) begin
                chk("start_busy", s_busy, 1'b1);
                chk("start_clr_tt", s_tt, 16'h0);
                chk("start_clr_pass", s_pass, 1'b0);
                chk("start_clr_fidx", s_fail, 4'd0);
            end
            if (poke && c == 8) begin
                if (s) start2 = 1'b1; else start0 = 1'b1;
            end
            if (c <= 20) xs[c-1] = s_x;
            if (s_done) begin
                got = 1'b1;
                lat = c;
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic        sel;
        logic [15:0] f;
        logic        pass;
        logic [3:0]  fidx;
        logic [4:0]  mism;
        bit          poke;
    } vec_t;

    vec_t vecs [10];
    int   lat;
    int   ndone;
    int   dpos [0:7];

    initial begin
        vecs[0] = '{1'b0, 16'h177E, 1'b1, 4'd0,  5'd0,  1'b0};
        vecs[1] = '{1'b1, 16'h177E, 1'b1, 4'd0,  5'd0,  1'b0};
        vecs[2] = '{1'b0, 16'h17FE, 1'b0, 4'd7,  5'd1,  1'b0};
        vecs[3] = '{1'b1, 16'h17FE, 1'b0, 4'd7,  5'd1,  1'b0};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 4'd1,  5'd10, 1'b0};
        vecs[5] = '{1'b0, 16'hFFFF, 1'b0, 4'd0,  5'd6,  1'b1};
        vecs[6] = '{1'b1, 16'hFFFF, 1'b0, 4'd0,  5'd6,  1'b1};
        vecs[7] = '{1'b0, 16'h977E, 1'b0, 4'd15, 5'd1,  1'b0};
        vecs[8] = '{1'b1, 16'h0000, 1'b0, 4'd1,  5'd10, 1'b0};
        vecs[9] = '{1'b0, 16'hE881, 1'b0, 4'd0,  5'd16, 1'b0};

        sel = 1'b0;
        rst = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk("rst_busy", s_busy, 1'b0);
            chk("rst_done", s_done, 1'b0);
            chk("rst_x", s_x, 4'd0);
            chk("rst_tt", s_tt, 16'h0);
            chk("rst_pass", s_pass, 1'b0);
            chk("rst_fidx", s_fail, 4'd0);
`ifdef MISMATCH_CNT_EN
            chk("rst_mism", s_mism, 5'd0);
`endif
        end
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_sweep(vecs[i].sel, vecs[i].f, vecs[i].poke, lat);
            chk("latency", lat, vecs[i].sel ? 32'd19 : 32'd17);
            chk("tt", s_tt, vecs[i].f);
            chk("pass", s_pass, vecs[i].pass);
            chk("fail_idx", s_fail, vecs[i].fidx);
            chk("done_busy", s_busy, 1'b0);
`ifdef MISMATCH_CNT_EN
            chk("mism_cnt", s_mism, vecs[i].mism);
`endif
            if (i == 1) begin
                for (int k = 0; k < 18; k++) begin
                    chk("x_seq", xs[k], (k < 16) ? k : 0);
                end
            end
            if (vecs[i].poke) begin
                if (vecs[i].sel) start2 = 1'b1; else start0 = 1'b1;
            end
            tick();
            start0 = 1'b0;
            start2 = 1'b0;
            chk("done_pulse", s_done, 1'b0);
            chk("idle_busy", s_busy, 1'b0);
            tick();
            chk("start_in_done_ignored", s_busy, 1'b0);
            chk("hold_pass", s_pass, vecs[i].pass);
            chk("hold_tt", s_tt, vecs[i].f);
        end

        // Reset in SWEEP cycle 8 aborts with no done pulse
        sel = 1'b0;
        f0 = 16'h177E;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 30 && x0 != 4'd8; c++) tick();
        chk("reach_cycle8", x0, 4'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy0, 1'b0);
        chk("abort_x", x0, 4'd0);
        chk("abort_tt", tt0, 16'h0);
        chk("abort_done", done0, 1'b0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (done0) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_sweep(1'b0, 16'h177E, 1'b0, lat);
        chk("after_abort_lat", lat, 17);
        chk("after_abort_tt", tt0, 16'h177E);
        chk("after_abort_pass", pass0, 1'b1);
        tick();
        tick();

        // start held high: back-to-back sweeps
        sel = 1'b0;
        ndone = 0;
        start0 = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done0) begin
                if (ndone < 8) dpos[ndone] = c;
                ndone++;
                chk("b2b_tt", tt0, 16'h177E);
                chk("b2b_pass", pass0, 1'b1);
            end
        end
        start0 = 1'b0;
        chk("b2b_count", ndone, 3);
        if (ndone >= 3) begin
            chk("b2b_first", dpos[0], 17);
            chk("b2b_gap1", dpos[1] - dpos[0], 18);
            chk("b2b_gap2", dpos[2] - dpos[1], 18);
        end
        for (int c = 0; c < 40; c++) tick();
        chk("b2b_idle", busy0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
